// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word accesses onto word-indexed sync memory; LSU_BOUNDS_CHECK_EN adds range errors.
// Latency: load 2, word store 1, sub-word store (read-modify-write) 3, rejected request 1 cycle after accept.
// Backpressure: req_ready is low whenever an access is in flight; one request outstanding at a time.
module load_store_unit #(
  parameter int MEM_DEPTH = 32
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_error,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        MemWrite,
  output logic        MemRead,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [2:0] {
    IDLE, LD_ISSUE, LD_CAPT, ST_ISSUE, RMW_RD, RMW_MERGE, RMW_WR, ERR_RESP
  } state_t;

  typedef struct packed {
    logic [1:0]  size;
    logic        sgn;
    logic [1:0]  lane;
    logic [15:0] wdata;
  } req_t;

  state_t state;
  req_t   req_q;
  logic   misaligned;
  logic   out_of_range;
  logic   req_err;

  assign req_ready = (state == IDLE) & ~Reset;

  assign misaligned = (req_size == 2'b11)
                    | ((req_size == 2'b01) & req_addr[0])
                    | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00));

  assign out_of_range = ({2'b00, req_addr[31:2]} >= 32'(MEM_DEPTH));

`ifdef LSU_BOUNDS_CHECK_EN
  assign req_err = misaligned | out_of_range;
`else
  logic unused_range;
  assign unused_range = out_of_range;
  assign req_err      = misaligned;
`endif

  function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] size,
                                          input logic sgn, input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   extract = {{24{sgn & b[7]}}, b};
      2'b01:   extract = {{16{sgn & h[15]}}, h};
      default: extract = word;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] word, input logic [1:0] size,
                                        input logic [1:0] lane, input logic [15:0] wd);
    merge = word;
    if (size == 2'b00) begin
      case (lane)
        2'd0:    merge[7:0]   = wd[7:0];
        2'd1:    merge[15:8]  = wd[7:0];
        2'd2:    merge[23:16] = wd[7:0];
        default: merge[31:24] = wd[7:0];
      endcase
    end else if (lane[1]) begin
      merge[31:16] = wd;
    end else begin
      merge[15:0] = wd;
    end
  endfunction

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state          <= IDLE;
      req_q          <= '0;
      resp_valid     <= 1'b0;
      resp_error     <= 1'b0;
      resp_rdata     <= 32'd0;
      mem_address    <= 32'd0;
      mem_write_data <= 32'd0;
      MemWrite       <= 1'b0;
      MemRead        <= 1'b0;
    end else begin
      // Strobes and response are single-cycle pulses unless re-asserted below.
      resp_valid <= 1'b0;
      resp_error <= 1'b0;
      resp_rdata <= 32'd0;
      MemRead    <= 1'b0;
      MemWrite   <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_q <= '{size: req_size, sgn: req_signed, lane: req_addr[1:0], wdata: req_wdata[15:0]};
            if (req_err) begin
              state <= ERR_RESP;
            end else begin
              mem_address <= {2'b00, req_addr[31:2]};
              if (!req_write) begin
                MemRead <= 1'b1;
                state   <= LD_ISSUE;
              end else if (req_size == 2'b10) begin
                MemWrite       <= 1'b1;
                mem_write_data <= req_wdata;
                state          <= ST_ISSUE;
              end else begin
                MemRead <= 1'b1;
                state   <= RMW_RD;
              end
            end
          end
        end
        LD_ISSUE: state <= LD_CAPT;
        LD_CAPT: begin
          resp_valid <= 1'b1;
          resp_rdata <= extract(mem_read_data, req_q.size, req_q.sgn, req_q.lane);
          state      <= IDLE;
        end
        ST_ISSUE: begin
          resp_valid <= 1'b1;
          state      <= IDLE;
        end
        RMW_RD: state <= RMW_MERGE;
        RMW_MERGE: begin
          MemWrite       <= 1'b1;
          mem_write_data <= merge(mem_read_data, req_q.size, req_q.lane, req_q.wdata);
          state          <= RMW_WR;
        end
        RMW_WR: begin
          resp_valid <= 1'b1;
          state      <= IDLE;
        end
        ERR_RESP: begin
          resp_valid <= 1'b1;
          resp_error <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
